// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter sharing one memory bus between the CPU core and a debug/loader port.
// Registered strobes last WAIT_CYC+1 cycles; completion is a one-cycle ack with captured read data.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W   = 13,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,

  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,

  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              cpu_stall,
  output logic              busy
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  // last_q / owner_q: 1 = debug port, 0 = CPU port
  logic                last_q, last_d;
  logic                owner_q, owner_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_rd_q, mem_rd_d;
  logic                mem_wr_q, mem_wr_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                dbg_ack_q, dbg_ack_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;
  logic                cpu_stall_q, cpu_stall_d;
  logic                busy_q, busy_d;

  logic                pick_dbg;
  logic                sel_we;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    owner_d     = owner_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    cpu_ack_d   = 1'b0;
    dbg_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    cpu_stall_d = cpu_stall_q;
    busy_d      = busy_q;
    pick_dbg    = 1'b0;
    sel_we      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cpu_req || dbg_req) begin
          // On a tie the port that was not served last wins.
          pick_dbg    = dbg_req && (!cpu_req || !last_q);
          sel_we      = pick_dbg ? dbg_we : cpu_we;
          owner_d     = pick_dbg;
          last_d      = pick_dbg;
          mem_addr_d  = pick_dbg ? dbg_addr : cpu_addr;
          mem_wdata_d = pick_dbg ? dbg_wdata : cpu_wdata;
          mem_rd_d    = !sel_we;
          mem_wr_d    = sel_we;
          cnt_d       = 3'(WAIT_CYC);
          cpu_stall_d = pick_dbg;
          busy_d      = 1'b1;
          state_d     = StAccess;
        end
      end

      StAccess: begin
        if (cnt_q == 3'd0) begin
          if (mem_rd_q) begin
            if (owner_q) begin
              dbg_rdata_d = mem_rdata;
            end else begin
              cpu_rdata_d = mem_rdata;
            end
          end
          mem_rd_d    = 1'b0;
          mem_wr_d    = 1'b0;
          cpu_stall_d = 1'b0;
          cpu_ack_d   = !owner_q;
          dbg_ack_d   = owner_q;
          state_d     = StDone;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end

      default: begin
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        cpu_stall_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      cpu_stall_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      cpu_ack_q   <= cpu_ack_d;
      dbg_ack_q   <= dbg_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
      cpu_stall_q <= cpu_stall_d;
      busy_q      <= busy_d;
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign dbg_ack   = dbg_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign cpu_stall = cpu_stall_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: timeline model of grants/strobes/acks checked every cycle,
// plus directed scenarios with literal expectations and WAIT_CYC=0/7 latency builds.
module tb_mem_bus_arbiter;

  localparam int W = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [12:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [12:0] dbg_addr = '0;
  logic [7:0]  dbg_wdata = '0;
  logic        cpu_ack, dbg_ack, mem_rd, mem_wr, cpu_stall, busy;
  logic [7:0]  cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic [12:0] mem_addr;

  function automatic logic [7:0] mem_fn(input logic [12:0] a);
    if (a == 13'h0010) return 8'hA5;
    return a[7:0] ^ {3'b000, a[12:8]} ^ 8'h5A;
  endfunction

  assign mem_rdata = mem_fn(mem_addr);

  mem_bus_arbiter #(.ADDR_W(13), .DATA_W(8), .WAIT_CYC(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .cpu_stall(cpu_stall), .busy(busy)
  );

  // Extra builds for the strobe-width / latency extremes.
  logic        rq0 = 1'b0, ak0, rd0, da0, wr0, st0, by0;
  logic [7:0]  cr0, dr0, wd0;
  logic [12:0] ma0;
  logic        rq7 = 1'b0, ak7, rd7, da7, wr7, st7, by7;
  logic [7:0]  cr7, dr7, wd7;
  logic [12:0] ma7;

  mem_bus_arbiter #(.ADDR_W(13), .DATA_W(8), .WAIT_CYC(0)) dut_w0 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(rq0), .cpu_we(1'b0), .cpu_addr(13'h0010), .cpu_wdata(8'h00),
    .cpu_ack(ak0), .cpu_rdata(cr0),
    .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(13'h0000), .dbg_wdata(8'h00),
    .dbg_ack(da0), .dbg_rdata(dr0),
    .mem_addr(ma0), .mem_wdata(wd0), .mem_rd(rd0), .mem_wr(wr0),
    .mem_rdata(8'hA5), .cpu_stall(st0), .busy(by0)
  );

  mem_bus_arbiter #(.ADDR_W(13), .DATA_W(8), .WAIT_CYC(7)) dut_w7 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(rq7), .cpu_we(1'b0), .cpu_addr(13'h0010), .cpu_wdata(8'h00),
    .cpu_ack(ak7), .cpu_rdata(cr7),
    .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(13'h0000), .dbg_wdata(8'h00),
    .dbg_ack(da7), .dbg_rdata(dr7),
    .mem_addr(ma7), .mem_wdata(wd7), .mem_rd(rd7), .mem_wr(wr7),
    .mem_rdata(8'hC3), .cpu_stall(st7), .busy(by7)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Timeline model: each grant at edge g occupies strobe cycles g..g+W, ack cycle g+W+1,
  // and the next request can be sampled no earlier than edge g+W+3.
  int          cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        m_active, m_dbg, m_we, m_last;
  logic [12:0] m_addr;
  logic [7:0]  m_wdata, m_crd, m_drd;
  int          m_g, m_next;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0; m_dbg <= 1'b0; m_we <= 1'b0; m_last <= 1'b1;
      m_addr <= '0; m_wdata <= '0; m_crd <= '0; m_drd <= '0;
      m_g <= 0; m_next <= 0;
    end else begin
      if (m_active && !m_we && (cyc + 1 == m_g + W + 1)) begin
        if (m_dbg) m_drd <= mem_fn(m_addr);
        else       m_crd <= mem_fn(m_addr);
      end
      if ((cyc + 1 >= m_next) && (cpu_req || dbg_req)) begin
        if (cpu_req && (!dbg_req || m_last)) begin
          m_dbg <= 1'b0; m_last <= 1'b0;
          m_we <= cpu_we; m_addr <= cpu_addr; m_wdata <= cpu_wdata;
        end else begin
          m_dbg <= 1'b1; m_last <= 1'b1;
          m_we <= dbg_we; m_addr <= dbg_addr; m_wdata <= dbg_wdata;
        end
        m_active <= 1'b1;
        m_g      <= cyc + 1;
        m_next   <= cyc + 1 + W + 3;
      end
    end
  end

  logic e_acc, e_rd, e_wr, e_stall, e_cack, e_dack, e_busy;
  always_comb begin
    e_acc   = m_active && (cyc >= m_g) && (cyc <= m_g + W);
    e_rd    = e_acc && !m_we;
    e_wr    = e_acc && m_we;
    e_stall = e_acc && m_dbg;
    e_cack  = m_active && !m_dbg && (cyc == m_g + W + 1);
    e_dack  = m_active && m_dbg && (cyc == m_g + W + 1);
    e_busy  = m_active && (cyc >= m_g) && (cyc <= m_g + W + 1);
  end

  logic chk_en = 1'b0;
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("mem_rd", mem_rd, e_rd);
      chk("mem_wr", mem_wr, e_wr);
      chk("cpu_stall", cpu_stall, e_stall);
      chk("busy", busy, e_busy);
      chk("cpu_ack", cpu_ack, e_cack);
      chk("dbg_ack", dbg_ack, e_dack);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("cpu_rdata", cpu_rdata, m_crd);
      chk("dbg_rdata", dbg_rdata, m_drd);
      chk("rd_wr_exclusive", mem_rd & mem_wr, 1'b0);
    end
  end

  // Event counters and ack log used by the directed scenarios.
  int          n_rd = 0, n_wr = 0, n_stall = 0, n_both = 0;
  logic [12:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  int          ack_cyc[$];
  int          ack_port[$];

  initial forever begin
    @(negedge clk);
    if (mem_rd) n_rd++;
    if (mem_wr) begin n_wr++; wr_addr = mem_addr; wr_data = mem_wdata; end
    if (mem_rd && mem_wr) n_both++;
    if (cpu_stall) n_stall++;
    if (cpu_ack) begin ack_cyc.push_back(cyc); ack_port.push_back(0); end
    if (dbg_ack) begin ack_cyc.push_back(cyc); ack_port.push_back(1); end
  end

  int t_start;

  // Each port holds its request until it has collected its number of acks.
  task automatic run_reqs(input int nc, input logic cwe, input logic [12:0] ca,
                          input logic [7:0] cw, input int nd, input logic dwe,
                          input logic [12:0] da, input logic [7:0] dw);
    int gc, gd, t;
    gc = 0; gd = 0; t = 0;
    @(negedge clk);
    cpu_we = cwe; cpu_addr = ca; cpu_wdata = cw;
    dbg_we = dwe; dbg_addr = da; dbg_wdata = dw;
    cpu_req = (nc > 0);
    dbg_req = (nd > 0);
    t_start = cyc;
    while ((cpu_req || dbg_req) && t < 100) begin
      @(negedge clk);
      t++;
      if (cpu_ack) begin gc++; if (gc >= nc) cpu_req = 1'b0; end
      if (dbg_ack) begin gd++; if (gd >= nd) dbg_req = 1'b0; end
    end
    chk("run_reqs_timeout", {30'd0, cpu_req, dbg_req}, 32'd0);
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic measure(input int sel, output int lat, output int width);
    lat = 0; width = 0;
    @(negedge clk);
    if (sel == 0) rq0 = 1'b1; else rq7 = 1'b1;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if ((sel == 0) ? rd0 : rd7) width++;
      if ((sel == 0) ? ak0 : ak7) begin
        lat = k;
        rq0 = 1'b0; rq7 = 1'b0;
      end
    end
    rq0 = 1'b0; rq7 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int b_rd, b_wr, b_st, b_ack, lat, wid;
    int exp_p[4];
    exp_p = '{0, 1, 0, 1};

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_mem_rd", mem_rd, 1'b0);
    chk("reset_cpu_rdata", cpu_rdata, 8'h00);
    chk("reset_mem_addr", mem_addr, 13'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    // CPU read 0x0010 -> 0xA5
    b_rd = n_rd; b_wr = n_wr; b_ack = ack_cyc.size();
    run_reqs(1, 1'b0, 13'h0010, 8'h00, 0, 1'b0, 13'h0000, 8'h00);
    chk("s1_rd_width", n_rd - b_rd, 2);
    chk("s1_wr_width", n_wr - b_wr, 0);
    chk("s1_ack_count", ack_cyc.size() - b_ack, 1);
    chk("s1_ack_latency", ack_cyc[b_ack] - t_start, 3);
    chk("s1_ack_port", ack_port[b_ack], 0);
    chk("s1_cpu_rdata", cpu_rdata, 8'hA5);
    chk("s1_dbg_rdata", dbg_rdata, 8'h00);

    // Debug write 0x1FFF <- 0x3C
    b_rd = n_rd; b_wr = n_wr; b_st = n_stall; b_ack = ack_cyc.size();
    run_reqs(0, 1'b0, 13'h0000, 8'h00, 1, 1'b1, 13'h1FFF, 8'h3C);
    chk("s2_wr_width", n_wr - b_wr, 2);
    chk("s2_rd_width", n_rd - b_rd, 0);
    chk("s2_stall_width", n_stall - b_st, 2);
    chk("s2_wr_addr", wr_addr, 13'h1FFF);
    chk("s2_wr_data", wr_data, 8'h3C);
    chk("s2_ack_count", ack_cyc.size() - b_ack, 1);
    chk("s2_ack_port", ack_port[b_ack], 1);
    chk("s2_dbg_rdata", dbg_rdata, 8'h00);
    chk("s2_cpu_rdata", cpu_rdata, 8'hA5);

    // Ties held for two grants each: strict alternation starting with CPU
    b_ack = ack_cyc.size();
    run_reqs(2, 1'b0, 13'h0030, 8'h00, 2, 1'b0, 13'h0040, 8'h00);
    chk("s3_ack_count", ack_cyc.size() - b_ack, 4);
    for (int i = 0; i < 4; i++) chk("s3_tie_order", ack_port[b_ack + i], exp_p[i]);
    chk("s3_grant_spacing", ack_cyc[b_ack + 3] - ack_cyc[b_ack], 12);
    chk("s3_cpu_rdata", cpu_rdata, 8'h6A);
    chk("s3_dbg_rdata", dbg_rdata, 8'h1A);

    b_ack = ack_cyc.size();
    run_reqs(1, 1'b0, 13'h0030, 8'h00, 1, 1'b0, 13'h0040, 8'h00);
    chk("s3b_first", ack_port[b_ack], 0);
    chk("s3b_second", ack_port[b_ack + 1], 1);

    run_reqs(1, 1'b0, 13'h0020, 8'h00, 0, 1'b0, 13'h0000, 8'h00);
    b_ack = ack_cyc.size();
    run_reqs(1, 1'b0, 13'h0030, 8'h00, 1, 1'b0, 13'h0040, 8'h00);
    chk("s3c_first", ack_port[b_ack], 1);
    chk("s3c_second", ack_port[b_ack + 1], 0);

    // CPU back-to-back, request held across three accesses
    b_rd = n_rd; b_ack = ack_cyc.size();
    run_reqs(3, 1'b0, 13'h0100, 8'h00, 0, 1'b0, 13'h0000, 8'h00);
    chk("s4_ack_count", ack_cyc.size() - b_ack, 3);
    chk("s4_spacing_1", ack_cyc[b_ack + 1] - ack_cyc[b_ack], 4);
    chk("s4_spacing_2", ack_cyc[b_ack + 2] - ack_cyc[b_ack + 1], 4);
    chk("s4_rd_width", n_rd - b_rd, 6);
    chk("s4_cpu_rdata", cpu_rdata, 8'h5B);

    // Reset during a debug read's ACCESS phase
    @(negedge clk);
    dbg_we = 1'b0; dbg_addr = 13'h1234; dbg_req = 1'b1;
    b_ack = ack_cyc.size();
    @(negedge clk);
    chk("s5_pre_rd", mem_rd, 1'b1);
    chk("s5_pre_stall", cpu_stall, 1'b1);
    #2 rst_n = 1'b0;
    dbg_req = 1'b0;
    #1;
    chk("s5_rd_dropped", mem_rd, 1'b0);
    chk("s5_stall_dropped", cpu_stall, 1'b0);
    chk("s5_busy_dropped", busy, 1'b0);
    chk("s5_no_ack_now", dbg_ack, 1'b0);
    chk("s5_mem_addr", mem_addr, 13'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("s5_no_ack", ack_cyc.size() - b_ack, 0);
    chk("s5_dbg_rdata", dbg_rdata, 8'h00);
    chk("s5_cpu_rdata", cpu_rdata, 8'h00);
    b_ack = ack_cyc.size();
    run_reqs(1, 1'b0, 13'h0020, 8'h00, 1, 1'b0, 13'h0040, 8'h00);
    chk("s5_tie_first", ack_port[b_ack], 0);
    chk("s5_tie_second", ack_port[b_ack + 1], 1);

    // WAIT_CYC extremes
    measure(0, lat, wid);
    chk("w0_ack_latency", lat, 2);
    chk("w0_rd_width", wid, 1);
    chk("w0_cpu_rdata", cr0, 8'hA5);
    measure(1, lat, wid);
    chk("w7_ack_latency", lat, 9);
    chk("w7_rd_width", wid, 8);
    chk("w7_cpu_rdata", cr7, 8'hC3);

    repeat (2) @(negedge clk);
    chk("no_rd_wr_overlap", n_both, 0);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
